message_cipher_engine: RTL and testbench



---
 rtl/message_cipher_engine.sv | 172 +++++++++++++++++
 tb/tb_message_cipher_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/message_cipher_engine.sv
// Multi-channel byte-stream cipher. Each message is combined one byte per cycle with a 16-bit
// LFSR keystream. Every channel keeps its own keystream state, so the stream continues from
// one message to the next on the same channel.
module message_cipher_engine #(
  parameter int unsigned MSG_BYTES    = 100,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned LW = $clog2(MSG_BYTES + 1),
  localparam int unsigned MW = 8 * MSG_BYTES
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_wr,
  input  logic [CW-1:0] key_chan,
  input  logic [15:0]   key_data,
  input  logic          start,
  input  logic [CW-1:0] chan,
  input  logic          mode,
  input  logic [LW-1:0] msg_len,
  input  logic [MW-1:0] in_message,
  output logic [MW-1:0] out_message,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [LW-1:0] k_q, k_d;
  logic [LW-1:0] len_q, len_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [MW-1:0] msg_q, msg_d;
  logic [MW-1:0] out_q, out_d;
  logic          key_hit_q, key_hit_d;
  logic          err_q, err_d;
  logic [15:0]   chan_state_q [NUM_CHANNELS];

  logic [15:0]   key_eff;
  logic          chan_ok;
  logic [LW-1:0] len_clamp;
  logic [15:0]   lfsr_next;
  logic [15:0]   start_state;
  logic [7:0]    p_byte;
  logic [7:0]    c_byte;

  // Key value to store, plus request decode helpers.
  always_comb begin
    key_eff   = (key_data == 16'h0000) ? SEED_DEFAULT : key_data;
    chan_ok   = (32'(chan) < NUM_CHANNELS);
    len_clamp = (32'(msg_len) > MSG_BYTES) ? LW'(MSG_BYTES) : msg_len;
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // A key written in the same cycle as the accepted start is the one the message uses.
    start_state = SEED_DEFAULT;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (chan == CW'(i)) start_state = chan_state_q[i];
    end
    if (key_wr && (key_chan == chan)) start_state = key_eff;
  end

  // Select the current plaintext byte and combine it with the keystream byte.
  always_comb begin
    p_byte = 8'h00;
    for (int i = 0; i < int'(MSG_BYTES); i++) begin
      if (k_q == LW'(i)) p_byte = msg_q[8*(int'(MSG_BYTES)-1-i) +: 8];
    end
    c_byte = mode_q ? (p_byte - lfsr_q[7:0]) : (p_byte + lfsr_q[7:0]);
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    k_d       = k_q;
    len_d     = len_q;
    mode_d    = mode_q;
    chan_d    = chan_q;
    msg_d     = msg_q;
    out_d     = out_q;
    key_hit_d = key_hit_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (chan_ok) begin
            msg_d     = in_message;
            mode_d    = mode;
            chan_d    = chan;
            len_d     = len_clamp;
            lfsr_d    = start_state;
            k_d       = '0;
            out_d     = '0;
            key_hit_d = 1'b0;
            state_d   = (len_clamp == '0) ? StDone : StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        for (int i = 0; i < int'(MSG_BYTES); i++) begin
          if (k_q == LW'(i)) out_d[8*(int'(MSG_BYTES)-1-i) +: 8] = c_byte;
        end
        lfsr_d = lfsr_next;
        k_d    = k_q + LW'(1);
        if (k_q == len_q - LW'(1)) state_d = StDone;
        // Remember a key rewrite so the stale working LFSR is not written back over it.
        if (key_wr && (key_chan == chan_q)) key_hit_d = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and datapath state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      lfsr_q    <= SEED_DEFAULT;
      k_q       <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      chan_q    <= '0;
      msg_q     <= '0;
      out_q     <= '0;
      key_hit_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      k_q       <= k_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      chan_q    <= chan_d;
      msg_q     <= msg_d;
      out_q     <= out_d;
      key_hit_q <= key_hit_d;
      err_q     <= err_d;
    end
  end

  // Per-channel keystream state; a key write takes priority over the end-of-message writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) chan_state_q[i] <= SEED_DEFAULT;
    end else begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        if (key_wr && (key_chan == CW'(i))) begin
          chan_state_q[i] <= key_eff;
        end else if ((state_q == StDone) && !key_hit_q && (chan_q == CW'(i))) begin
          chan_state_q[i] <= lfsr_q;
        end
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy        = (state_q == StRun);
    done        = (state_q == StDone);
    err         = err_q;
    out_message = out_q;
  end

endmodule

// File: tb/tb_message_cipher_engine.sv
// Scoreboard bench for message_cipher_engine: expected results are queued at start time and
// compared when done pulses, alongside fixed reference vectors.
module tb_message_cipher_engine;

  localparam int MB = 16;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int LW = 5;
  localparam int W  = 8 * MB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          key_wr = 1'b0;
  logic [CW-1:0] key_chan = '0;
  logic [15:0]   key_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] chan = '0;
  logic          mode = 1'b0;
  logic [LW-1:0] msg_len = '0;
  logic [W-1:0]  in_message = '0;
  logic [W-1:0]  out_message;
  logic          busy, done, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [W-1:0] sb_out[$];
  int           sb_cyc[$];
  string        sb_tag[$];
  logic [W-1:0] last_out = '0;
  logic [15:0]  m_st [NC];
  logic [W-1:0] hi_msg;
  logic [W-1:0] hi_enc;

  message_cipher_engine #(
    .MSG_BYTES   (MB),
    .NUM_CHANNELS(NC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_wr     (key_wr),
    .key_chan   (key_chan),
    .key_data   (key_data),
    .start      (start),
    .chan       (chan),
    .mode       (mode),
    .msg_len    (msg_len),
    .in_message (in_message),
    .out_message(out_message),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference keystream model of one message.
  task automatic model_msg(input logic md, input int len, input logic [W-1:0] data,
                           input logic [15:0] st_in, output logic [W-1:0] res,
                           output logic [15:0] st_out);
    logic [W-1:0] tmp;
    logic [15:0] st;
    logic [7:0] p, o;
    int l;
    l   = (len > MB) ? MB : len;
    tmp = data;
    st  = st_in;
    res = '0;
    for (int i = 0; i < l; i++) begin
      p   = tmp[W-1 -: 8];
      tmp = tmp << 8;
      o   = md ? p - st[7:0] : p + st[7:0];
      res = {res[W-9:0], o};
      st  = {st[14:0], st[15] ^ st[13] ^ st[12] ^ st[10]};
    end
    res    = res << (8 * (MB - l));
    st_out = st;
  endtask

  task automatic send(input int ch, input logic md, input int len, input logic [W-1:0] data,
                      input string tag);
    logic [W-1:0] r;
    logic [15:0] so;
    int l;
    l = (len > MB) ? MB : len;
    model_msg(md, len, data, m_st[ch], r, so);
    m_st[ch] = so;
    sb_out.push_back(r);
    sb_cyc.push_back(cyc + l + 1);
    sb_tag.push_back(tag);
    chan       = CW'(ch);
    mode       = md;
    msg_len    = LW'(len);
    in_message = data;
    start      = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    key_wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < MB + 20 && sb_out.size() > 0; i++) @(negedge clock);
    if (sb_out.size() != 0) begin
      check({tag, "_timeout"}, W'(sb_out.size()), '0);
      sb_out.delete();
      sb_cyc.delete();
      sb_tag.delete();
    end
    @(negedge clock);
  endtask

  task automatic write_key(input int ch, input logic [15:0] kd);
    key_wr   = 1'b1;
    key_chan = CW'(ch);
    key_data = kd;
    m_st[ch] = (kd == 16'h0) ? 16'hACE1 : kd;
  endtask

  // Scoreboard monitor: compare output and completion cycle at every done pulse.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb_out.size() == 0) begin
        check("spurious_done", W'(1), W'(0));
      end else begin
        check({sb_tag[0], "_out"}, out_message, sb_out[0]);
        check({sb_tag[0], "_cycle"}, W'(cyc), W'(sb_cyc[0]));
        void'(sb_out.pop_front());
        void'(sb_cyc.pop_front());
        void'(sb_tag.pop_front());
      end
      last_out = out_message;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    for (int i = 0; i < NC; i++) m_st[i] = 16'hACE1;
    hi_msg = '0;
    hi_msg[W-1 -: 16] = 16'h4869;
    hi_enc = '0;
    hi_enc[W-1 -: 16] = 16'h292C;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_err", W'(err), '0);
    check("rst_out", out_message, '0);

    send(0, 1'b0, 2, hi_msg, "enc_hi_ch0");
    drain("enc_hi_ch0");
    check("enc_hi_ch0_ref", last_out, hi_enc);

    d = '0;
    d[W-1 -: 8] = 8'h41;
    send(0, 1'b0, 1, d, "enc_a_ch0");
    drain("enc_a_ch0");
    check("enc_a_ch0_ref", last_out[W-1 -: 8], W'(8'hC8));

    write_key(0, 16'hACE1);
    @(negedge clock);
    key_wr = 1'b0;
    send(0, 1'b1, 2, hi_enc, "dec_hi_ch0");
    drain("dec_hi_ch0");
    check("dec_hi_ch0_ref", last_out, hi_msg);

    send(1, 1'b0, 2, hi_msg, "enc_hi_ch1");
    drain("enc_hi_ch1");
    check("enc_hi_ch1_ref", last_out, hi_enc);

    write_key(2, 16'h0000);
    @(negedge clock);
    key_wr = 1'b0;
    send(2, 1'b0, 2, hi_msg, "zero_key_ch2");
    drain("zero_key_ch2");
    check("zero_key_ch2_ref", last_out, hi_enc);

    // Key write in the same cycle as the accepted start.
    write_key(1, 16'hBEEF);
    send(1, 1'b0, 3, {$urandom, $urandom, $urandom, $urandom}, "samecyc_key_ch1");
    drain("samecyc_key_ch1");

    send(0, 1'b0, 0, hi_msg, "len0_ch0");
    drain("len0_ch0");
    send(0, 1'b0, 2, hi_msg, "after_len0_ch0");
    drain("after_len0_ch0");

    send(1, 1'b1, MB + 5, {$urandom, $urandom, $urandom, $urandom}, "clamp_ch1");
    drain("clamp_ch1");

    chan    = CW'(NC);
    msg_len = LW'(2);
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("bad_chan_err", W'(err), W'(1));
    check("bad_chan_busy", W'(busy), '0);
    @(negedge clock);
    check("bad_chan_err_clear", W'(err), '0);
    check("bad_chan_busy2", W'(busy), '0);

    // Ignored start and key rewrite of the active channel mid-message.
    d = '0;
    d[W-1 -: 32] = 32'h41424344;
    send(0, 1'b0, 4, d, "collide_ch0");
    in_message = hi_msg;
    chan       = CW'(1);
    start      = 1'b1;
    write_key(0, 16'h1234);
    @(negedge clock);
    start  = 1'b0;
    key_wr = 1'b0;
    check("collide_busy", W'(busy), W'(1));
    check("collide_err", W'(err), '0);
    drain("collide_ch0");
    send(0, 1'b0, 2, hi_msg, "post_key_ch0");
    drain("post_key_ch0");
    check("post_key_ch0_ref", last_out[W-1 -: 16], W'(16'h7CD2));

    // Synchronous reset while byte 1 of a 3-byte message is in flight.
    send(1, 1'b0, 3, hi_msg, "abort_ch1");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_out", out_message, '0);
    sb_out.delete();
    sb_cyc.delete();
    sb_tag.delete();
    for (int i = 0; i < NC; i++) m_st[i] = 16'hACE1;
    for (int c = 0; c < NC; c++) begin
      send(c, 1'b0, 2, hi_msg, $sformatf("fresh_hi_ch%0d", c));
      drain("fresh_hi");
      check($sformatf("fresh_hi_ch%0d_ref", c), last_out, hi_enc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
